// File: rtl/adder_pipe_pkg.sv
// Shared constants and stage-register layout for the pipelined slice adder.
package adder_pipe_pkg;

  localparam int unsigned DEF_NUM_BITS   = 16;
  localparam int unsigned DEF_NUM_STAGES = 4;
  localparam int unsigned MAX_BITS       = 64;

  // Sized for the widest legal build; narrower builds use the low NUM_BITS bits.
  typedef struct packed {
    logic                valid;
    logic                carry;
    logic [MAX_BITS-1:0] psum;
    logic [MAX_BITS-1:0] pend_a;
    logic [MAX_BITS-1:0] pend_b;
  } stage_reg_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder slice with carry in/out.
module adder_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[W];
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined NUM_BITS adder: one W-bit slice per stage, per-stage valid with bubble collapsing.
// Build option: define ADDER_PIPE_SAT_EN to force sum to all ones when overflow is set.
module adder_pipe_nbit
  import adder_pipe_pkg::*;
#(
  parameter int unsigned NUM_BITS   = DEF_NUM_BITS,
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int unsigned W = NUM_BITS / NUM_STAGES;

  if (NUM_BITS < 4 || NUM_BITS > MAX_BITS) begin : g_bad_width
    $error("adder_pipe_nbit: NUM_BITS must lie in 4..64");
  end
  if ((NUM_BITS % NUM_STAGES) != 0) begin : g_bad_stages
    $error("adder_pipe_nbit: NUM_STAGES must divide NUM_BITS");
  end

  stage_reg_t            st     [NUM_STAGES];
  stage_reg_t            st_nxt [NUM_STAGES];
  logic [W-1:0]          sl_a   [NUM_STAGES];
  logic [W-1:0]          sl_b   [NUM_STAGES];
  logic [W-1:0]          sl_sum [NUM_STAGES];
  logic                  sl_cin [NUM_STAGES];
  logic                  sl_cout[NUM_STAGES];
  logic [NUM_STAGES-1:0] adv;

  // Stage 0 adds straight from the ports; later stages take the low pending slice.
  always_comb begin
    sl_a[0]   = a[W-1:0];
    sl_b[0]   = b[W-1:0];
    sl_cin[0] = carry_in;
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      sl_a[k]   = st[k-1].pend_a[W-1:0];
      sl_b[k]   = st[k-1].pend_b[W-1:0];
      sl_cin[k] = st[k-1].carry;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
    adder_slice #(.W(W)) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (sl_cin[k]),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k])
    );
  end

  // Pending operands shift down one slice per stage, so each stage always reads bits [W-1:0].
  always_comb begin
    st_nxt[0]        = '0;
    st_nxt[0].valid  = in_valid;
    st_nxt[0].carry  = sl_cout[0];
    st_nxt[0].psum   = MAX_BITS'(sl_sum[0]);
    st_nxt[0].pend_a = MAX_BITS'(a) >> W;
    st_nxt[0].pend_b = MAX_BITS'(b) >> W;
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      st_nxt[k]        = '0;
      st_nxt[k].valid  = st[k-1].valid;
      st_nxt[k].carry  = sl_cout[k];
      st_nxt[k].psum   = st[k-1].psum | (MAX_BITS'(sl_sum[k]) << (k * W));
      st_nxt[k].pend_a = st[k-1].pend_a >> W;
      st_nxt[k].pend_b = st[k-1].pend_b >> W;
    end
  end

  always_comb begin
    adv                 = '0;
    adv[NUM_STAGES-1]   = !st[NUM_STAGES-1].valid || out_ready;
    for (int unsigned k = NUM_STAGES - 1; k > 0; k--) begin
      adv[k-1] = !st[k-1].valid || adv[k];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        st[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if (adv[k]) begin
          st[k] <= st_nxt[k];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = st[NUM_STAGES-1].valid;
  assign overflow  = st[NUM_STAGES-1].carry;

`ifdef ADDER_PIPE_SAT_EN
  assign sum = st[NUM_STAGES-1].carry ? '1 : st[NUM_STAGES-1].psum[NUM_BITS-1:0];
`else
  assign sum = st[NUM_STAGES-1].psum[NUM_BITS-1:0];
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Randomized self-checking bench for adder_pipe_nbit (16/4 default, plus 32/8 and 8/1 builds).
module tb_adder_pipe_nbit;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [15:0] a16, b16, sum16;
  logic        cin16, iv16, ir16, ov16, vo16, or16;
  logic [31:0] a32, b32, sum32;
  logic        cin32, iv32, ir32, ov32, vo32, or32;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, iv8, ir8, ov8, vo8, or8;

  adder_pipe_nbit #(.NUM_BITS(16), .NUM_STAGES(4)) u_dut16 (
    .clk(clk), .n_rst(n_rst), .a(a16), .b(b16), .carry_in(cin16), .in_valid(iv16),
    .in_ready(ir16), .sum(sum16), .overflow(ov16), .out_valid(vo16), .out_ready(or16));
  adder_pipe_nbit #(.NUM_BITS(32), .NUM_STAGES(8)) u_dut32 (
    .clk(clk), .n_rst(n_rst), .a(a32), .b(b32), .carry_in(cin32), .in_valid(iv32),
    .in_ready(ir32), .sum(sum32), .overflow(ov32), .out_valid(vo32), .out_ready(or32));
  adder_pipe_nbit #(.NUM_BITS(8), .NUM_STAGES(1)) u_dut8 (
    .clk(clk), .n_rst(n_rst), .a(a8), .b(b8), .carry_in(cin8), .in_valid(iv8),
    .in_ready(ir8), .sum(sum8), .overflow(ov8), .out_valid(vo8), .out_ready(or8));

  int          checks = 0;
  int          fails  = 0;
  int unsigned cyc    = 0;
  logic [16:0] q16 [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Returns {overflow, sum} for an nb-bit add, sum zero-extended to 64 bits.
  function automatic logic [64:0] model(input int unsigned nb, input logic [63:0] x,
                                        input logic [63:0] y, input logic c);
    logic [64:0] full;
    logic [63:0] mask;
    logic        ovf;
    full = {1'b0, x} + {1'b0, y} + 65'(c);
    mask = (nb >= 64) ? '1 : ((64'd1 << nb) - 64'd1);
    ovf  = full[nb];
`ifdef ADDER_PIPE_SAT_EN
    if (ovf) return {1'b1, mask};
`endif
    return {ovf, full[63:0] & mask};
  endfunction

  function automatic logic [16:0] exp16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [64:0] e;
    e = model(16, 64'(x), 64'(y), c);
    return {e[64], e[15:0]};
  endfunction

  // Drive one cycle's inputs just after the edge; return at the following negedge.
  task automatic step16(input logic iv, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic ordy);
    @(posedge clk);
    #1;
    iv16 = iv; a16 = av; b16 = bv; cin16 = cv; or16 = ordy;
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    iv16 = 1'b1; or16 = 1'b0; a16 = '1; b16 = '1; cin16 = 1'b1;
    @(negedge clk);
    checks++; if (vo16 !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", vo16); end
    checks++; if (sum16 !== 16'h0) begin fails++; $display("FAIL rst_sum: got %h, required 0000", sum16); end
    checks++; if (ov16 !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b, required 0", ov16); end
    checks++; if (ir16 !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", ir16); end
    checks++; if (vo32 !== 1'b0 || vo8 !== 1'b0) begin
      fails++; $display("FAIL rst_sweep_valid: got %b/%b, required 0/0", vo32, vo8);
    end
    n_rst = 1'b1;
    iv16 = 1'b0; or16 = 1'b1;
  endtask

  task automatic test_single_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                                input string name);
    logic [16:0] e;
    int unsigned acc, lat;
    bit          seen;
    e = exp16(av, bv, cv);
    seen = 0; lat = 0;
    step16(1'b1, av, bv, cv, 1'b1);
    checks++; if (ir16 !== 1'b1) begin fails++; $display("FAIL %s_accept: in_ready=%b, required 1", name, ir16); end
    acc = cyc;
    for (int i = 0; i < 16 && !seen; i++) begin
      step16(1'b0, '0, '0, 1'b0, 1'b1);
      if (vo16 === 1'b1) begin seen = 1; lat = cyc - acc; end
    end
    checks++; if (!seen || lat != 4) begin
      fails++; $display("FAIL %s_latency: got %0d cycles (seen=%0b), required 4", name, lat, seen);
    end
    checks++; if ({ov16, sum16} !== e) begin
      fails++; $display("FAIL %s_result: got ov=%b sum=%h, required ov=%b sum=%h", name, ov16, sum16, e[16], e[15:0]);
    end
    step16(1'b0, '0, '0, 1'b0, 1'b1);
    checks++; if (vo16 !== 1'b0) begin fails++; $display("FAIL %s_once: out_valid=%b after retire, required 0", name, vo16); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] av, bv;
    logic        cv, iv;
    logic [16:0] e;
    int          sent, got, bad_rdy;
    int unsigned first, last;
    sent = 0; got = 0; bad_rdy = 0; first = 0; last = 0;
    q16.delete();
    for (int i = 0; i < 200 && got < 100; i++) begin
      iv = (sent < 100);
      av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom);
      step16(iv, av, bv, cv, 1'b1);
      if (vo16 === 1'b1) begin
        checks++;
        if (q16.size() == 0) begin
          fails++; $display("FAIL b2b_spurious: out_valid=1 with nothing outstanding, required 0");
        end else begin
          e = q16.pop_front();
          if ({ov16, sum16} !== e) begin
            fails++; $display("FAIL b2b_result[%0d]: got ov=%b sum=%h, required ov=%b sum=%h", got, ov16, sum16, e[16], e[15:0]);
          end
        end
        if (got == 0) first = cyc;
        last = cyc;
        got++;
      end
      if (iv) begin
        if (ir16 === 1'b1) begin q16.push_back(exp16(av, bv, cv)); sent++; end
        else bad_rdy++;
      end
    end
    checks++; if (bad_rdy != 0) begin fails++; $display("FAIL b2b_in_ready: %0d stalled cycles, required 0", bad_rdy); end
    checks++; if (got != 100) begin fails++; $display("FAIL b2b_count: got %0d results, required 100", got); end
    checks++; if (last - first != 99) begin fails++; $display("FAIL b2b_gapless: span %0d cycles, required 99", last - first); end
  endtask

  task automatic test_backpressure;
    logic [15:0] av, bv;
    logic        cv;
    logic [16:0] e;
    int          acc;
    q16.delete();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom);
      step16(1'b1, av, bv, cv, 1'b0);
      if (ir16 === 1'b1) begin q16.push_back(exp16(av, bv, cv)); acc++; end
    end
    checks++; if (acc != 4) begin fails++; $display("FAIL bp_accept_count: got %0d, required 4", acc); end
    for (int i = 0; i < 6; i++) begin
      step16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      checks++;
      if (vo16 !== 1'b1 || ir16 !== 1'b0 || {ov16, sum16} !== q16[0]) begin
        fails++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b ov=%b sum=%h, required 1 0 ov=%b sum=%h",
                          i, vo16, ir16, ov16, sum16, q16[0][16], q16[0][15:0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom);
      step16(1'b1, av, bv, cv, 1'b1);
      if (i == 0) begin
        checks++; if (ir16 !== 1'b1) begin fails++; $display("FAIL bp_full_accept: in_ready=%b, required 1", ir16); end
      end
      if (vo16 === 1'b1 && q16.size() > 0) begin
        checks++; e = q16.pop_front();
        if ({ov16, sum16} !== e) begin
          fails++; $display("FAIL bp_swap: got ov=%b sum=%h, required ov=%b sum=%h", ov16, sum16, e[16], e[15:0]);
        end
      end
      if (ir16 === 1'b1) q16.push_back(exp16(av, bv, cv));
    end
    for (int i = 0; i < 20 && q16.size() > 0; i++) begin
      step16(1'b0, '0, '0, 1'b0, 1'b1);
      if (vo16 === 1'b1) begin
        checks++; e = q16.pop_front();
        if ({ov16, sum16} !== e) begin
          fails++; $display("FAIL bp_drain: got ov=%b sum=%h, required ov=%b sum=%h", ov16, sum16, e[16], e[15:0]);
        end
      end
    end
    checks++; if (q16.size() != 0) begin fails++; $display("FAIL bp_drain_empty: %0d left, required 0", q16.size()); end
    step16(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset;
    int stale;
    q16.delete();
    for (int i = 0; i < 3; i++) step16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) step16(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (vo16 !== 1'b1) begin fails++; $display("FAIL mrst_pre: out_valid=%b, required 1", vo16); end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (vo16 !== 1'b0 || sum16 !== 16'h0 || ov16 !== 1'b0 || ir16 !== 1'b1) begin
      fails++; $display("FAIL mrst_async: out_valid=%b sum=%h ov=%b in_ready=%b, required 0 0000 0 1", vo16, sum16, ov16, ir16);
    end
    @(negedge clk);
    n_rst = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step16(1'b0, '0, '0, 1'b0, 1'b1);
      if (vo16 !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin fails++; $display("FAIL mrst_stale: %0d valid cycles, required 0", stale); end
    test_single_op(16'h1234, 16'h4321, 1'b0, "mrst_after");
  endtask

  task automatic sweep_op(input int unsigned nb, input int unsigned lat_req,
                          input logic [63:0] av, input logic [63:0] bv, input logic cv);
    logic [64:0] e, got;
    int unsigned acc, lat;
    bit          seen;
    logic        rdy, vld;
    e = model(nb, av, bv, cv);
    seen = 0; lat = 0; got = '0;
    @(posedge clk);
    #1;
    if (nb == 32) begin a32 = av[31:0]; b32 = bv[31:0]; cin32 = cv; iv32 = 1'b1; end
    else begin a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; iv8 = 1'b1; end
    @(negedge clk);
    rdy = (nb == 32) ? ir32 : ir8;
    acc = cyc;
    for (int i = 0; i < 24 && !seen; i++) begin
      @(posedge clk);
      #1;
      iv32 = 1'b0; iv8 = 1'b0;
      @(negedge clk);
      vld = (nb == 32) ? vo32 : vo8;
      if (vld === 1'b1) begin
        seen = 1; lat = cyc - acc;
        got = (nb == 32) ? {ov32, 32'd0, sum32} : {ov8, 56'd0, sum8};
      end
    end
    checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL sweep%0d_accept: in_ready=%b, required 1", nb, rdy); end
    checks++; if (!seen || lat != lat_req) begin
      fails++; $display("FAIL sweep%0d_latency: got %0d (seen=%0b), required %0d", nb, lat, seen, lat_req);
    end
    checks++; if (got !== e) begin
      fails++; $display("FAIL sweep%0d_result: got ov=%b sum=%h, required ov=%b sum=%h", nb, got[64], got[63:0], e[64], e[63:0]);
    end
  endtask

  task automatic test_sweep;
    sweep_op(32, 8, 64'hFFFF_FFFF, 64'h1, 1'b0);
    sweep_op(32, 8, 64'h0000_FFFF, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++) sweep_op(32, 8, 64'($urandom), 64'($urandom), 1'($urandom));
    sweep_op(8, 1, 64'hFF, 64'h0, 1'b1);
    sweep_op(8, 1, 64'h0F, 64'h01, 1'b0);
    for (int i = 0; i < 4; i++) sweep_op(8, 1, 64'($urandom_range(255)), 64'($urandom_range(255)), 1'($urandom));
  endtask

  initial begin
    a16 = '0; b16 = '0; cin16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
    a32 = '0; b32 = '0; cin32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
    a8  = '0; b8  = '0; cin8  = 1'b0; iv8  = 1'b0; or8  = 1'b1;
    test_reset;
    test_single_op(16'hFFFF, 16'h0001, 1'b0, "single_wrap");
    test_single_op(16'h0FFF, 16'h0001, 1'b0, "ripple_slice");
    test_single_op(16'h7FFF, 16'h0000, 1'b1, "ripple_cin");
    test_back_to_back;
    test_backpressure;
    test_mid_reset;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
